// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: global advance, load-use bubbles,
// taken-branch redirect handshake and stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int XLEN         = 64,
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_ready,
  input  logic             id_ready,
  input  logic             ex_ready,
  input  logic             mem_ready,
  input  logic             wb_ready,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_wd,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_target,
  input  logic             redirect_ready,
  output logic             advance,
  output logic             if_hold,
  output logic             id_bubble,
  output logic             flush_if_id,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             busy_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LDSTALL  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [1:0] BUB_INIT = 2'(LOAD_BUBBLES - 1);

  state_t     state_q, state_d;
  logic [1:0] bub_q, bub_d;
  logic       hazard, redir, hs;
  logic       take_redir, stall_inc;

  assign advance = if_ready & id_ready & ex_ready
                 & mem_ready & wb_ready;

  assign hazard = ex_valid & ex_is_load & (ex_wd != 5'd0)
                & id_valid
                & ((id_rs1 == ex_wd) | (id_rs2 == ex_wd));

  assign redir      = ex_valid & br_taken;
  assign hs         = redirect_valid & redirect_ready;
  assign busy_stall = (state_q != RUN);

  always_comb begin
    state_d     = state_q;
    bub_d       = bub_q;
    if_hold     = 1'b0;
    id_bubble   = 1'b0;
    flush_if_id = 1'b0;
    take_redir  = 1'b0;
    stall_inc   = 1'b0;
    case (state_q)
      RUN: begin
        if (advance && redir) begin
          take_redir = 1'b1;
        end else if (advance && hazard) begin
          if_hold   = 1'b1;
          id_bubble = 1'b1;
          stall_inc = 1'b1;
          if (LOAD_BUBBLES > 1) begin
            state_d = LDSTALL;
            bub_d   = BUB_INIT;
          end
        end
      end
      LDSTALL: begin
        if (advance && redir) begin
          take_redir = 1'b1;
        end else if (advance) begin
          if_hold   = 1'b1;
          id_bubble = 1'b1;
          stall_inc = 1'b1;
          bub_d     = bub_q - 2'd1;
          if (bub_q == 2'd1) state_d = RUN;
        end
      end
      REDIRECT: begin
        flush_if_id = advance;
        id_bubble   = advance;
        // a fresh redirect keeps the request pending
        if (advance && redir) begin
          take_redir = 1'b1;
        end else if (hs) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (take_redir) begin
      flush_if_id = 1'b1;
      id_bubble   = 1'b1;
      if_hold     = 1'b0;
      bub_d       = 2'd0;
      state_d     = REDIRECT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      bub_q          <= 2'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      stall_cnt      <= '0;
      flush_cnt      <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      if (take_redir) begin
        redirect_valid <= 1'b1;
        redirect_pc    <= br_target;
        flush_cnt      <= flush_cnt + CNT_W'(1);
      end else if (hs) begin
        redirect_valid <= 1'b0;
      end
      if (stall_inc) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random
// stimulus against a behavioural model, LOAD_BUBBLES 1 and 2.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ready, id_ready, ex_ready, mem_ready, wb_ready;
  logic        id_valid, ex_valid, ex_is_load, br_taken;
  logic [4:0]  id_rs1, id_rs2, ex_wd;
  logic [63:0] br_target;
  logic        redirect_ready;

  logic        o_adv [2];
  logic        o_hold [2];
  logic        o_bub [2];
  logic        o_fl [2];
  logic        o_rv [2];
  logic [63:0] o_rpc [2];
  logic        o_busy [2];
  logic [31:0] o_stall [2];
  logic [31:0] o_fcnt [2];

  int checks = 0;
  int fails  = 0;

  // model state per instance (0: one bubble, 1: two bubbles)
  int          lb [2] = '{1, 2};
  bit          m_pend [2];
  int          m_left [2];
  logic [63:0] m_pc [2];
  logic [31:0] m_stall [2];
  logic [31:0] m_flush [2];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LOAD_BUBBLES(1)) dut_a (
    .clk(clk), .rst(rst),
    .if_ready(if_ready), .id_ready(id_ready),
    .ex_ready(ex_ready), .mem_ready(mem_ready),
    .wb_ready(wb_ready), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_wd(ex_wd), .br_taken(br_taken),
    .br_target(br_target),
    .redirect_ready(redirect_ready),
    .advance(o_adv[0]), .if_hold(o_hold[0]),
    .id_bubble(o_bub[0]), .flush_if_id(o_fl[0]),
    .redirect_valid(o_rv[0]), .redirect_pc(o_rpc[0]),
    .busy_stall(o_busy[0]), .stall_cnt(o_stall[0]),
    .flush_cnt(o_fcnt[0])
  );

  pipe_hazard_ctrl #(.LOAD_BUBBLES(2)) dut_b (
    .clk(clk), .rst(rst),
    .if_ready(if_ready), .id_ready(id_ready),
    .ex_ready(ex_ready), .mem_ready(mem_ready),
    .wb_ready(wb_ready), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_wd(ex_wd), .br_taken(br_taken),
    .br_target(br_target),
    .redirect_ready(redirect_ready),
    .advance(o_adv[1]), .if_hold(o_hold[1]),
    .id_bubble(o_bub[1]), .flush_if_id(o_fl[1]),
    .redirect_valid(o_rv[1]), .redirect_pc(o_rpc[1]),
    .busy_stall(o_busy[1]), .stall_cnt(o_stall[1]),
    .flush_cnt(o_fcnt[1])
  );

  task automatic idle_inputs();
    if_ready = 1; id_ready = 1; ex_ready = 1;
    mem_ready = 1; wb_ready = 1;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0;
    ex_valid = 0; ex_is_load = 0; ex_wd = 0;
    br_taken = 0; br_target = '0; redirect_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_left[k] = 0; m_pc[k] = '0;
      m_stall[k] = '0; m_flush[k] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_hazard(input logic [4:0] wd,
                            input logic [4:0] r1,
                            input logic [4:0] r2);
    ex_valid = 1; ex_is_load = 1; ex_wd = wd;
    id_valid = 1; id_rs1 = r1; id_rs2 = r2;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_hold[k], o_bub[k], o_fl[k], o_rv[k], o_busy[k]}
          !== 5'b0 || o_rpc[k] !== '0 || o_stall[k] !== '0
          || o_fcnt[k] !== '0) begin
        fails++;
        $display("FAIL reset dut%0d got hold%b bub%b fl%b rv%b busy%b pc%h sc%0d fc%0d exp all zero",
                 k, o_hold[k], o_bub[k], o_fl[k], o_rv[k],
                 o_busy[k], o_rpc[k], o_stall[k], o_fcnt[k]);
      end
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    set_hazard(5'd5, 5'd5, 5'd0);
    @(negedge clk);
    checks++;
    if (o_hold[0] !== 1 || o_bub[0] !== 1 || o_fl[0] !== 0) begin
      fails++;
      $display("FAIL load_use_bubble got hold%b bub%b fl%b exp 1 1 0",
               o_hold[0], o_bub[0], o_fl[0]);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (o_hold[0] !== 0 || o_bub[0] !== 0 || o_busy[0] !== 0
        || o_stall[0] !== 32'd1) begin
      fails++;
      $display("FAIL load_use_after got hold%b bub%b busy%b sc%0d exp 0 0 0 1",
               o_hold[0], o_bub[0], o_busy[0], o_stall[0]);
    end
  endtask

  task automatic test_no_hazard();
    logic [4:0] wd [3] = '{5'd0, 5'd5, 5'd5};
    logic [4:0] r1 [3] = '{5'd0, 5'd7, 5'd4};
    logic [4:0] r2 [3] = '{5'd0, 5'd6, 5'd6};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_hazard(wd[i], r1[i], r2[i]);
      @(negedge clk);
      checks++;
      if (o_hold[0] !== 0 || o_bub[0] !== 0
          || o_hold[1] !== 0 || o_bub[1] !== 0) begin
        fails++;
        $display("FAIL no_hazard_%0d got hold%b%b bub%b%b exp 0",
                 i, o_hold[0], o_hold[1], o_bub[0], o_bub[1]);
      end
      tick();
    end
    checks++;
    if (o_stall[0] !== 0 || o_stall[1] !== 0) begin
      fails++;
      $display("FAIL no_hazard_cnt got %0d %0d exp 0",
               o_stall[0], o_stall[1]);
    end
  endtask

  task automatic test_multi_bubble();
    int nbub = 0;
    do_reset();
    set_hazard(5'd5, 5'd5, 5'd0);
    @(negedge clk);
    if (o_bub[1] === 1) nbub++;
    tick();
    idle_inputs();
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (o_adv[1] !== 0 || o_bub[1] !== 0 || o_busy[1] !== 1
          || o_stall[1] !== 32'd1) begin
        fails++;
        $display("FAIL freeze_%0d got adv%b bub%b busy%b sc%0d exp 0 0 1 1",
                 i, o_adv[1], o_bub[1], o_busy[1], o_stall[1]);
      end
      if (o_bub[1] === 1) nbub++;
      tick();
    end
    mem_ready = 1;
    @(negedge clk);
    checks++;
    if (o_hold[1] !== 1 || o_bub[1] !== 1) begin
      fails++;
      $display("FAIL second_bubble got hold%b bub%b exp 1 1",
               o_hold[1], o_bub[1]);
    end
    if (o_bub[1] === 1) nbub++;
    tick();
    @(negedge clk);
    if (o_bub[1] === 1) nbub++;
    checks++;
    if (nbub != 2 || o_stall[1] !== 32'd2 || o_busy[1] !== 0) begin
      fails++;
      $display("FAIL multi_bubble got n%0d sc%0d busy%b exp 2 2 0",
               nbub, o_stall[1], o_busy[1]);
    end
  endtask

  task automatic test_redirect();
    int nrv = 0;
    do_reset();
    ex_valid = 1; br_taken = 1;
    br_target = 64'h0000_0000_8000_0040;
    @(negedge clk);
    checks++;
    if (o_fl[0] !== 1 || o_bub[0] !== 1 || o_rv[0] !== 0) begin
      fails++;
      $display("FAIL redir_take got fl%b bub%b rv%b exp 1 1 0",
               o_fl[0], o_bub[0], o_rv[0]);
    end
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      redirect_ready = (i == 2);
      @(negedge clk);
      if (o_rv[0] === 1) nrv++;
      checks++;
      if (o_rv[0] !== 1 || o_rpc[0] !== 64'h8000_0040
          || o_fl[0] !== 1 || o_busy[0] !== 1
          || o_fcnt[0] !== 32'd1) begin
        fails++;
        $display("FAIL redir_wait_%0d got rv%b pc%h fl%b busy%b fc%0d exp 1 80000040 1 1 1",
                 i, o_rv[0], o_rpc[0], o_fl[0], o_busy[0],
                 o_fcnt[0]);
      end
      tick();
    end
    redirect_ready = 0;
    @(negedge clk);
    checks++;
    if (o_rv[0] !== 0 || o_busy[0] !== 0 || nrv != 3) begin
      fails++;
      $display("FAIL redir_done got rv%b busy%b n%0d exp 0 0 3",
               o_rv[0], o_busy[0], nrv);
    end
  endtask

  task automatic test_hazard_and_branch();
    do_reset();
    set_hazard(5'd5, 5'd5, 5'd0);
    br_taken = 1; br_target = 64'h1234;
    @(negedge clk);
    checks++;
    if (o_hold[1] !== 0 || o_fl[1] !== 1 || o_bub[1] !== 1) begin
      fails++;
      $display("FAIL both_cycle got hold%b fl%b bub%b exp 0 1 1",
               o_hold[1], o_fl[1], o_bub[1]);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (o_rv[1] !== 1 || o_hold[1] !== 0 || o_stall[1] !== 0
        || o_stall[0] !== 0 || o_rpc[1] !== 64'h1234) begin
      fails++;
      $display("FAIL both_after got rv%b hold%b sc%0d/%0d pc%h exp 1 0 0 1234",
               o_rv[1], o_hold[1], o_stall[1], o_stall[0],
               o_rpc[1]);
    end
  endtask

  task automatic test_reset_in_redirect();
    do_reset();
    ex_valid = 1; br_taken = 1; br_target = 64'hABC0;
    tick();
    idle_inputs();
    @(negedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if (o_rv[0] !== 0 || o_busy[0] !== 0 || o_fcnt[0] !== 0
        || o_stall[0] !== 0 || o_rpc[0] !== '0) begin
      fails++;
      $display("FAIL async_reset got rv%b busy%b fc%0d sc%0d pc%h exp 0",
               o_rv[0], o_busy[0], o_fcnt[0], o_stall[0],
               o_rpc[0]);
    end
    do_reset();
  endtask

  task automatic test_random();
    bit adv, hz, rd;
    bit e_hold, e_bub, e_fl;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if_ready  = ($urandom_range(0, 9) != 0);
      id_ready  = ($urandom_range(0, 9) != 0);
      ex_ready  = ($urandom_range(0, 9) != 0);
      mem_ready = ($urandom_range(0, 9) != 0);
      wb_ready  = ($urandom_range(0, 9) != 0);
      id_valid  = ($urandom_range(0, 3) != 0);
      ex_valid  = ($urandom_range(0, 3) != 0);
      ex_is_load = $urandom_range(0, 1);
      ex_wd  = 5'($urandom_range(0, 3));
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      br_taken = ($urandom_range(0, 7) == 0);
      br_target = {$urandom, $urandom};
      redirect_ready = $urandom_range(0, 1);
      adv = if_ready && id_ready && ex_ready
            && mem_ready && wb_ready;
      hz = ex_valid && ex_is_load && ex_wd != 0 && id_valid
           && (id_rs1 == ex_wd || id_rs2 == ex_wd);
      rd = ex_valid && br_taken;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        e_hold = 0; e_bub = 0; e_fl = 0;
        if (adv && rd) begin
          e_fl = 1; e_bub = 1;
        end else if (m_pend[k]) begin
          e_fl = adv; e_bub = adv;
        end else if (m_left[k] > 0 || hz) begin
          e_hold = adv; e_bub = adv;
        end
        checks++;
        if (o_adv[k] !== adv || o_hold[k] !== e_hold
            || o_bub[k] !== e_bub || o_fl[k] !== e_fl) begin
          fails++;
          $display("FAIL rand_ctl dut%0d cyc%0d got a%b h%b b%b f%b exp a%b h%b b%b f%b",
                   k, c, o_adv[k], o_hold[k], o_bub[k], o_fl[k],
                   adv, e_hold, e_bub, e_fl);
        end
        checks++;
        if (o_rv[k] !== m_pend[k] || o_rpc[k] !== m_pc[k]
            || o_busy[k] !== (m_pend[k] || m_left[k] > 0)) begin
          fails++;
          $display("FAIL rand_redir dut%0d cyc%0d got rv%b pc%h busy%b exp rv%b pc%h",
                   k, c, o_rv[k], o_rpc[k], o_busy[k],
                   m_pend[k], m_pc[k]);
        end
        checks++;
        if (o_stall[k] !== m_stall[k]
            || o_fcnt[k] !== m_flush[k]) begin
          fails++;
          $display("FAIL rand_cnt dut%0d cyc%0d got sc%0d fc%0d exp sc%0d fc%0d",
                   k, c, o_stall[k], o_fcnt[k],
                   m_stall[k], m_flush[k]);
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        if (adv && rd) begin
          m_pend[k] = 1; m_pc[k] = br_target;
          m_left[k] = 0; m_flush[k] = m_flush[k] + 1;
        end else if (m_pend[k]) begin
          if (redirect_ready) m_pend[k] = 0;
        end else if (m_left[k] > 0) begin
          if (adv) begin
            m_left[k]--; m_stall[k] = m_stall[k] + 1;
          end
        end else if (adv && hz) begin
          m_stall[k] = m_stall[k] + 1;
          m_left[k] = lb[k] - 1;
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_multi_bubble();
    test_redirect();
    test_hazard_and_branch();
    test_reset_in_redirect();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
